// File: rtl/child_share_arbiter.sv
// Round-robin time-sharing of one single-bit CHILD cell between N_REQ requesters.
// Each transaction: grant, drive CHILD I for CHILD_LAT+1 cycles, sample CHILD O, strobe the response.
module child_share_arbiter #(
  parameter int N_REQ     = 4,
  parameter int CHILD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] req_i,
  output logic [N_REQ-1:0] gnt,
  output logic [N_REQ-1:0] rsp_valid,
  output logic             rsp_o,
  output logic             busy,
  output logic             child_i,
  input  logic             child_o,
  output logic [1:0]       dbg_state_o
);

  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       lat_cnt_q, lat_cnt_d;
  logic [IW-1:0]    rr_last_q, rr_last_d;
  logic [IW-1:0]    wsel_q, wsel_d;
  logic             data_q, data_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic             rsp_o_q, rsp_o_d;

  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic [IW-1:0]    cand;

  // Scan from the farthest candidate back to rr_last+1 so the last hit is the highest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      cand = IW'((int'(rr_last_q) + i) % N_REQ);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    lat_cnt_d   = lat_cnt_q;
    rr_last_d   = rr_last_q;
    wsel_d      = wsel_q;
    data_d      = data_q;
    gnt_d       = '0;
    rsp_valid_d = '0;
    rsp_o_d     = rsp_o_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          data_d         = req_i[win_idx];
          wsel_d         = win_idx;
          rr_last_d      = win_idx;
          lat_cnt_d      = 3'(CHILD_LAT);
          gnt_d[win_idx] = 1'b1;
          state_d        = DRIVE;
        end
      end
      DRIVE: begin
        if (lat_cnt_q != 3'd0) begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end else begin
          rsp_o_d             = child_o;
          rsp_valid_d[wsel_q] = 1'b1;
          state_d             = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_cnt_q   <= 3'd0;
      rr_last_q   <= IW'(N_REQ - 1);
      wsel_q      <= '0;
      data_q      <= 1'b0;
      gnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_o_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      rr_last_q   <= rr_last_d;
      wsel_q      <= wsel_d;
      data_q      <= data_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_o_q     <= rsp_o_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_o       = rsp_o_q;
  assign busy        = (state_q != IDLE);
  assign child_i     = (state_q == DRIVE) & data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_child_share_arbiter.sv
// Bench for child_share_arbiter: directed scenarios plus randomized requesters,
// checked every cycle against a timestamp-based transaction model.
module tb_child_share_arbiter;

  localparam int N   = 4;
  localparam int LAT = 1;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0] req   = '0;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] gnt, rsp_valid;
  logic         rsp_o, busy, child_i, child_o;
  logic [1:0]   dbg_state;

  child_share_arbiter #(.N_REQ(N), .CHILD_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_i(req_i), .gnt(gnt),
    .rsp_valid(rsp_valid), .rsp_o(rsp_o), .busy(busy), .child_i(child_i),
    .child_o(child_o), .dbg_state_o(dbg_state)
  );

  // CHILD cell: inverter with LAT cycles of delay
  logic pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= ~child_i;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign child_o = pipe[LAT-1];

  int n_vec = 0;
  int n_err = 0;
  int k = 0;
  logic chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, k);
    end
  endtask

  // Transaction model: a transaction starting (first grant cycle) at m_t0 owns the cell
  // for LAT+1 drive cycles, one response cycle, then one idle cycle before re-arbitration.
  logic m_active = 1'b0;
  int   m_t0 = 0;
  int   m_w = 0;
  logic m_data = 1'b0;
  int   m_rr = N - 1;
  logic m_rsp = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    int pick = -1;
    for (int i = 1; i <= N; i++) begin
      int idx = (last + i) % N;
      if (pick < 0 && r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always @(posedge clk) begin
    k <= k + 1;
    if (rst) begin
      m_active <= 1'b0;
      m_rr     <= N - 1;
      m_rsp    <= 1'b0;
    end else if (!m_active) begin
      if (req != '0) begin
        m_active <= 1'b1;
        m_t0     <= k + 1;
        m_w      <= rr_pick(req, m_rr);
        m_data   <= req_i[rr_pick(req, m_rr)];
        m_rr     <= rr_pick(req, m_rr);
      end
    end else begin
      // Inverting cell: the sampled value is the complement of the driven data.
      if (k + 1 == m_t0 + LAT + 1) m_rsp <= ~m_data;
      if (k + 1 == m_t0 + LAT + 2) m_active <= 1'b0;
    end
  end

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(gnt), (m_active && k == m_t0) ? (32'(1) << m_w) : 32'(0));
      check("rsp_valid", 32'(rsp_valid),
            (m_active && k == m_t0 + LAT + 1) ? (32'(1) << m_w) : 32'(0));
      check("child_i", 32'(child_i),
            (m_active && k >= m_t0 && k <= m_t0 + LAT) ? 32'(m_data) : 32'(0));
      check("busy", 32'(busy), 32'(m_active));
      check("rsp_o", 32'(rsp_o), 32'(m_rsp));
    end
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int c = 0; c < budget && busy; c++) tick();
    check("idle_timeout", 32'(busy), 32'(0));
  endtask

  function automatic int oh_idx(input logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  logic [1:0] exp_q[$];
  int   got_g[$];
  int   got_t[$];
  logic got_r[$];
  logic exp_r[$];
  logic [N-1:0] pend;
  int   seen;

  initial begin
    // Reset state
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
    check("rst_rsp_o", 32'(rsp_o), 32'(0));
    check("rst_child_i", 32'(child_i), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    tick(); tick();

    // Single request from requester 2
    req = 4'b0100; req_i = 4'b0100;
    tick();
    check("s_gnt", 32'(gnt), 32'h4);
    check("s_child_i0", 32'(child_i), 32'(1));
    check("s_busy0", 32'(busy), 32'(1));
    req = '0;
    tick();
    check("s_gnt_off", 32'(gnt), 32'(0));
    check("s_child_i1", 32'(child_i), 32'(1));
    tick();
    check("s_rsp_valid", 32'(rsp_valid), 32'h4);
    check("s_rsp_o", 32'(rsp_o), 32'(0));
    check("s_busy2", 32'(busy), 32'(1));
    tick();
    check("s_idle", 32'(busy), 32'(0));

    // Continuous contention from reset
    do_reset();
    req = 4'b1111; req_i = 4'b1010;
    for (int c = 0; c < 40 && got_g.size() < 5; c++) begin
      tick();
      if (gnt != '0) begin got_g.push_back(oh_idx(gnt)); got_t.push_back(k); end
      if (rsp_valid != '0) got_r.push_back(rsp_o);
    end
    req = '0;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    exp_r = '{1'b1, 1'b0, 1'b1, 1'b0};
    check("c_ngnt", 32'(got_g.size()), 32'(5));
    check("c_nrsp", 32'(got_r.size()), 32'(4));
    for (int i = 0; i < 5 && i < got_g.size(); i++) check("c_order", 32'(got_g[i]), 32'(exp_q[i]));
    for (int i = 0; i < 4 && i + 1 < got_t.size(); i++)
      check("c_spacing", 32'(got_t[i+1] - got_t[i]), 32'(LAT + 3));
    for (int i = 0; i < 4 && i < got_r.size(); i++) check("c_rsp_o", 32'(got_r[i]), 32'(exp_r[i]));
    wait_idle(20);

    // Fairness after winner 1
    do_reset();
    req = 4'b0010; req_i = 4'b0000;
    for (int c = 0; c < 10 && gnt == '0; c++) tick();
    check("f_first", 32'(gnt), 32'h2);
    req = 4'b1011;
    got_g.delete();
    for (int c = 0; c < 30 && got_g.size() < 3; c++) begin
      tick();
      if (gnt != '0) got_g.push_back(oh_idx(gnt));
    end
    req = '0;
    exp_q = '{2'd3, 2'd0, 2'd1};
    check("f_ngnt", 32'(got_g.size()), 32'(3));
    for (int i = 0; i < 3 && i < got_g.size(); i++) check("f_order", 32'(got_g[i]), 32'(exp_q[i]));
    wait_idle(20);

    // Reset during the second DRIVE cycle
    do_reset();
    req = 4'b0001; req_i = 4'b0001;
    tick();
    check("r_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    check("r_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("r_gnt0", 32'(gnt), 32'(0));
    check("r_rsp0", 32'(rsp_valid), 32'(0));
    check("r_child0", 32'(child_i), 32'(0));
    check("r_busy0", 32'(busy), 32'(0));
    seen = 0;
    for (int c = 0; c < 6; c++) begin tick(); if (rsp_valid != '0) seen++; end
    check("r_no_rsp", 32'(seen), 32'(0));
    req = 4'b1000;
    tick();
    check("r_fresh", 32'(gnt), 32'h8);
    req = '0;
    wait_idle(20);

    // Withdrawn request while busy
    do_reset();
    req = 4'b0001; req_i = 4'b0000;
    tick();
    req = '0;
    tick();
    req = 4'b0010;
    tick();
    req = '0;
    seen = 0;
    for (int c = 0; c < 8; c++) begin tick(); if (gnt[1] || rsp_valid[1]) seen++; end
    check("w_none", 32'(seen), 32'(0));

    // Randomized requesters with occasional reset
    pend = '0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (pend[i]) begin
          if (gnt[i]) pend[i] = 1'b0;
          else if ($urandom_range(0, 31) == 0) pend[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
        end
      end
      req   = pend;
      req_i = N'($urandom);
      rst   = ($urandom_range(0, 199) == 0);
    end
    rst = 1'b0;
    req = '0;
    wait_idle(20);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
